// File: rtl/dht11_pkg.sv
// Shared DHT11 bus definitions: responder states, default protocol timing and frame helpers.
package dht11_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HOST_LOW,
        ST_RESP_DLY,
        ST_PRES_LOW,
        ST_PRES_HIGH,
        ST_BIT_LOW,
        ST_BIT_HIGH,
        ST_END_LOW
    } dht11_state_e;

    localparam int unsigned DHT_CLKS_PER_US  = 50;
    localparam int unsigned DHT_START_MIN_US = 18000;
    localparam int unsigned DHT_RESP_DLY_US  = 30;
    localparam int unsigned DHT_PRES_LOW_US  = 80;
    localparam int unsigned DHT_PRES_HIGH_US = 80;
    localparam int unsigned DHT_BIT_LOW_US   = 50;
    localparam int unsigned DHT_BIT0_HIGH_US = 26;
    localparam int unsigned DHT_BIT1_HIGH_US = 70;

    localparam int unsigned DHT_FRAME_W = 40;

    function automatic logic [7:0] chk8(input logic [7:0] b0, input logic [7:0] b1,
                                        input logic [7:0] b2, input logic [7:0] b3);
        logic [9:0] sum;
        sum = {2'b00, b0} + {2'b00, b1} + {2'b00, b2} + {2'b00, b3};
        return sum[7:0];
    endfunction

endpackage

// File: rtl/dht11_us_tick.sv
// Microsecond prescaler; restart realigns the tick so each phase is an exact number of microseconds.
module dht11_us_tick #(
    parameter int unsigned CLKS_PER_US = 50
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_restart,
    output logic o_tick
);

    localparam int unsigned CW = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_US - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_restart || (r_cnt == LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/dht11_responder.sv
// DHT11 device emulator: answers a host start pulse with presence and a 40-bit frame, open-drain.
module dht11_responder
    import dht11_pkg::*;
#(
    parameter int unsigned CLKS_PER_US  = DHT_CLKS_PER_US,
    parameter int unsigned START_MIN_US = DHT_START_MIN_US,
    parameter int unsigned RESP_DLY_US  = DHT_RESP_DLY_US,
    parameter int unsigned PRES_LOW_US  = DHT_PRES_LOW_US,
    parameter int unsigned PRES_HIGH_US = DHT_PRES_HIGH_US,
    parameter int unsigned BIT_LOW_US   = DHT_BIT_LOW_US,
    parameter int unsigned BIT0_HIGH_US = DHT_BIT0_HIGH_US,
    parameter int unsigned BIT1_HIGH_US = DHT_BIT1_HIGH_US
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN,
    input  logic       DQ_IN,
    output logic       DQ_OE,
    input  logic [7:0] HUM_INT,
    input  logic [7:0] HUM_FLOAT,
    input  logic [7:0] TEMP_INT,
    input  logic [7:0] TEMP_FLOAT,
    input  logic       CRC_CORRUPT,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERROR
);

    dht11_state_e r_state, w_next;

    logic                   r_dq_meta, r_dq_s;
    logic                   w_tick, w_entry;
    logic [14:0]            r_us_cnt, w_phase_us;
    logic                   w_phase_end, w_collide, w_bit;
    logic [DHT_FRAME_W-1:0] r_frame;
    logic [5:0]             r_bit_idx;
    logic [7:0]             w_chk;
    logic                   r_done, r_error, w_done_set, w_err_set;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_dq_meta <= 1'b1;
            r_dq_s    <= 1'b1;
        end else begin
            r_dq_meta <= DQ_IN;
            r_dq_s    <= r_dq_meta;
        end
    end

    assign w_entry = (w_next != r_state);

    dht11_us_tick #(
        .CLKS_PER_US(CLKS_PER_US)
    ) u_us_tick (
        .i_clk    (CLK),
        .i_rst_n  (RST),
        .i_restart(w_entry),
        .o_tick   (w_tick)
    );

    always_ff @(posedge CLK) begin
        if (!RST || w_entry) begin
            r_us_cnt <= '0;
        end else if (w_tick && (r_us_cnt != '1)) begin
            r_us_cnt <= r_us_cnt + 15'd1;
        end
    end

    assign w_chk = chk8(HUM_INT, HUM_FLOAT, TEMP_INT, TEMP_FLOAT) ^ {8{CRC_CORRUPT}};
    assign w_bit = r_frame[r_bit_idx];

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_frame   <= '0;
            r_bit_idx <= '0;
        end else if ((r_state == ST_HOST_LOW) && (w_next == ST_RESP_DLY)) begin
            r_frame   <= {HUM_INT, HUM_FLOAT, TEMP_INT, TEMP_FLOAT, w_chk};
            r_bit_idx <= 6'(DHT_FRAME_W - 1);
        end else if ((r_state == ST_BIT_HIGH) && (w_next == ST_BIT_LOW)) begin
            r_bit_idx <= r_bit_idx - 6'd1;
        end
    end

    always_comb begin
        case (r_state)
            ST_RESP_DLY:          w_phase_us = 15'(RESP_DLY_US);
            ST_PRES_LOW:          w_phase_us = 15'(PRES_LOW_US);
            ST_PRES_HIGH:         w_phase_us = 15'(PRES_HIGH_US);
            ST_BIT_LOW, ST_END_LOW: w_phase_us = 15'(BIT_LOW_US);
            ST_BIT_HIGH:          w_phase_us = w_bit ? 15'(BIT1_HIGH_US) : 15'(BIT0_HIGH_US);
            default:              w_phase_us = 15'd1;
        endcase
    end

    // Phase ends on the tick that completes its last microsecond; us_cnt>=2 masks synchroniser lag.
    assign w_phase_end = w_tick && (r_us_cnt == (w_phase_us - 15'd1));
    assign w_collide   = !r_dq_s && (r_us_cnt >= 15'd2);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= w_done_set;
            r_error <= w_err_set;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_done_set = 1'b0;
        w_err_set  = 1'b0;
        if (!EN) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!r_dq_s) w_next = ST_HOST_LOW;
                end
                ST_HOST_LOW: begin
                    if (r_dq_s) begin
                        w_next = (r_us_cnt >= 15'(START_MIN_US)) ? ST_RESP_DLY : ST_IDLE;
                    end
                end
                ST_RESP_DLY: begin
                    if (w_collide) begin
                        w_next    = ST_IDLE;
                        w_err_set = 1'b1;
                    end else if (w_phase_end) begin
                        w_next = ST_PRES_LOW;
                    end
                end
                ST_PRES_LOW: begin
                    if (w_phase_end) w_next = ST_PRES_HIGH;
                end
                ST_PRES_HIGH: begin
                    if (w_collide) begin
                        w_next    = ST_IDLE;
                        w_err_set = 1'b1;
                    end else if (w_phase_end) begin
                        w_next = ST_BIT_LOW;
                    end
                end
                ST_BIT_LOW: begin
                    if (w_phase_end) w_next = ST_BIT_HIGH;
                end
                ST_BIT_HIGH: begin
                    if (w_collide) begin
                        w_next    = ST_IDLE;
                        w_err_set = 1'b1;
                    end else if (w_phase_end) begin
                        w_next = (r_bit_idx == 6'd0) ? ST_END_LOW : ST_BIT_LOW;
                    end
                end
                ST_END_LOW: begin
                    if (w_phase_end) begin
                        w_next     = ST_IDLE;
                        w_done_set = 1'b1;
                    end
                end
                default: w_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        DQ_OE = 1'b0;
        BUSY  = 1'b0;
        case (r_state)
            ST_PRES_LOW, ST_BIT_LOW, ST_END_LOW: begin
                DQ_OE = 1'b1;
                BUSY  = 1'b1;
            end
            ST_RESP_DLY, ST_PRES_HIGH, ST_BIT_HIGH: BUSY = 1'b1;
            default: ;
        endcase
    end

    assign DONE  = r_done;
    assign ERROR = r_error;

endmodule

// File: tb/tb_dht11_responder.sv
// Bench for dht11_responder: protocol-level waveform model checked every cycle plus decoded-frame literals.
module tb_dht11_responder;

    localparam int CPU      = 4;
    localparam int START_US = 20;
    localparam int RESP_US  = 30;
    localparam int PLOW_US  = 80;
    localparam int PHIGH_US = 80;
    localparam int BLOW_US  = 50;
    localparam int B0_US    = 26;
    localparam int B1_US    = 70;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       EN = 1'b1;
    logic       host_low = 1'b0;
    logic       CRC_CORRUPT = 1'b0;
    logic [7:0] HUM_INT = '0, HUM_FLOAT = '0, TEMP_INT = '0, TEMP_FLOAT = '0;
    logic       DQ_IN, DQ_OE, BUSY, DONE, ERROR;

    // Open-drain bus with pull-up: low when either end pulls.
    assign DQ_IN = !(DQ_OE || host_low);

    dht11_responder #(
        .CLKS_PER_US (CPU),
        .START_MIN_US(START_US),
        .RESP_DLY_US (RESP_US),
        .PRES_LOW_US (PLOW_US),
        .PRES_HIGH_US(PHIGH_US),
        .BIT_LOW_US  (BLOW_US),
        .BIT0_HIGH_US(B0_US),
        .BIT1_HIGH_US(B1_US)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .EN         (EN),
        .DQ_IN      (DQ_IN),
        .DQ_OE      (DQ_OE),
        .HUM_INT    (HUM_INT),
        .HUM_FLOAT  (HUM_FLOAT),
        .TEMP_INT   (TEMP_INT),
        .TEMP_FLOAT (TEMP_FLOAT),
        .CRC_CORRUPT(CRC_CORRUPT),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .ERROR      (ERROR)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int cyc_idx = 0;
    int lo_runs[$];
    int hi_runs[$];
    int hi_start[40];
    logic [3:0] exp_q[$];
    logic [3:0] model_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h want=0x%0h", name, act, exp);
        end
    endtask

    task automatic push_n(input int n, input logic [3:0] v);
        repeat (n) model_q.push_back(v);
    endtask

    // Expected {DQ_OE,BUSY,DONE,ERROR} per cycle from the pull that starts a host-low of L us.
    task automatic model_frame(input int L, input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] c, input logic [7:0] d, input logic corrupt);
        int sum;
        logic [7:0] chk;
        logic [39:0] bits;
        sum  = (int'(a) + int'(b) + int'(c) + int'(d)) % 256;
        chk  = corrupt ? 8'(255 - sum) : 8'(sum);
        bits = {a, b, c, d, chk};
        model_q.delete();
        push_n(4 * L + 2, 4'b0000);
        push_n(RESP_US * CPU, 4'b0100);
        push_n(PLOW_US * CPU, 4'b1100);
        push_n(PHIGH_US * CPU, 4'b0100);
        for (int i = 39; i >= 0; i--) begin
            push_n(BLOW_US * CPU, 4'b1100);
            hi_start[39 - i] = model_q.size();
            push_n((bits[i] ? B1_US : B0_US) * CPU, 4'b0100);
        end
        push_n(BLOW_US * CPU, 4'b1100);
        push_n(1, 4'b0010);
        push_n(24, 4'b0000);
    endtask

    // kind: 0 none, 1 host pulls at m, 2 EN dropped at m, 3 RST asserted at m
    task automatic run_scenario(input int L, input int kind, input int m);
        int keep;
        int total;
        @(negedge CLK);
        lo_runs.delete();
        hi_runs.delete();
        done_cnt = 0;
        err_cnt  = 0;
        cyc_idx  = 0;
        keep = (kind == 0) ? model_q.size() : ((kind == 1) ? m + 2 : m);
        for (int j = 0; j < keep; j++) exp_q.push_back(model_q[j]);
        if (kind == 1) exp_q.push_back(4'b0001);
        if (kind != 0) repeat (60) exp_q.push_back(4'b0000);
        total = exp_q.size();
        host_low = 1'b1;
        for (int n = 1; n <= total; n++) begin
            @(negedge CLK);
            if (n == 4 * L) host_low = 1'b0;
            if (kind == 1 && n == m) host_low = 1'b1;
            if (kind == 1 && n == m + 20) host_low = 1'b0;
            if (kind == 2 && n == m) EN = 1'b0;
            if (kind == 2 && n == m + 40) EN = 1'b1;
            if (kind == 3 && n == m) RST = 1'b0;
            if (kind == 3 && n == m + 3) RST = 1'b1;
        end
        check("stream_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_frame(input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                               input logic [7:0] e3, input logic [7:0] e4);
        logic [39:0] got;
        logic [7:0] want[5];
        want = '{e0, e1, e2, e3, e4};
        check("low_run_count", 32'(lo_runs.size()), 32'd42);
        check("high_run_count", 32'(hi_runs.size()), 32'd42);
        check("done_pulses", 32'(done_cnt), 32'd1);
        check("error_pulses", 32'(err_cnt), 32'd0);
        if (lo_runs.size() == 42 && hi_runs.size() == 42) begin
            check("presence_low_cycles", 32'(hi_runs[0]), 32'd320);
            check("presence_high_cycles", 32'(lo_runs[1]), 32'd320);
            check("bit_low_cycles", 32'(hi_runs[1]), 32'd200);
            for (int i = 0; i < 40; i++) got[39 - i] = (lo_runs[2 + i] > 150);
            for (int k = 0; k < 5; k++) begin
                check($sformatf("frame_byte%0d", k), 32'(got[39 - 8 * k -: 8]), 32'(want[k]));
            end
        end
    endtask

    initial begin : compare_proc
        logic [3:0] act;
        logic [3:0] e;
        logic prev_busy;
        logic prev_oe;
        int run;
        prev_busy = 1'b0;
        prev_oe   = 1'b0;
        run       = 0;
        forever begin
            @(posedge CLK);
            #1;
            act = {DQ_OE, BUSY, DONE, ERROR};
            if (DONE === 1'b1) done_cnt++;
            if (ERROR === 1'b1) err_cnt++;
            if (BUSY === 1'b1) begin
                if (!prev_busy) begin
                    run = 1;
                    prev_oe = DQ_OE;
                end else if (DQ_OE === prev_oe) begin
                    run++;
                end else begin
                    if (prev_oe) hi_runs.push_back(run);
                    else lo_runs.push_back(run);
                    run = 1;
                    prev_oe = DQ_OE;
                end
            end else if (prev_busy) begin
                if (prev_oe) hi_runs.push_back(run);
                else lo_runs.push_back(run);
            end
            prev_busy = (BUSY === 1'b1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (act !== e) begin
                    failures++;
                    $display("FAIL stream[%0d] {oe,busy,done,err} got=%b want=%b", cyc_idx, act, e);
                end
                cyc_idx++;
            end
        end
    end

    initial begin
        repeat (3) @(negedge CLK);
        check("reset_dq_oe", 32'(DQ_OE), 32'd0);
        check("reset_busy", 32'(BUSY), 32'd0);
        check("reset_done", 32'(DONE), 32'd0);
        check("reset_error", 32'(ERROR), 32'd0);
        RST = 1'b1;
        repeat (20) @(negedge CLK);

        HUM_INT = 8'h37; HUM_FLOAT = 8'h00; TEMP_INT = 8'h19; TEMP_FLOAT = 8'h05;
        model_frame(25, 8'h37, 8'h00, 8'h19, 8'h05, 1'b0);
        run_scenario(25, 0, 0);
        check_frame(8'h37, 8'h00, 8'h19, 8'h05, 8'h55);
        if (lo_runs.size() == 42) begin
            check("bit0_high_cycles", 32'(lo_runs[2]), 32'd104);
            check("bit1_high_cycles", 32'(lo_runs[4]), 32'd280);
        end

        model_q.delete();
        push_n(4 * 10 + 40, 4'b0000);
        run_scenario(10, 0, 0);
        check("glitch_error_pulses", 32'(err_cnt), 32'd0);
        check("glitch_done_pulses", 32'(done_cnt), 32'd0);

        model_frame(25, 8'h37, 8'h00, 8'h19, 8'h05, 1'b0);
        run_scenario(25, 1, hi_start[7] + 40);
        check("abort_error_pulses", 32'(err_cnt), 32'd1);
        check("abort_done_pulses", 32'(done_cnt), 32'd0);

        HUM_INT = 8'hFF; HUM_FLOAT = 8'hFF; TEMP_INT = 8'hFF; TEMP_FLOAT = 8'hFF;
        model_frame(25, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0);
        run_scenario(25, 0, 0);
        check_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFC);

        HUM_INT = 8'h37; HUM_FLOAT = 8'h00; TEMP_INT = 8'h19; TEMP_FLOAT = 8'h05;
        CRC_CORRUPT = 1'b1;
        model_frame(25, 8'h37, 8'h00, 8'h19, 8'h05, 1'b1);
        run_scenario(25, 0, 0);
        check_frame(8'h37, 8'h00, 8'h19, 8'h05, 8'hAA);
        CRC_CORRUPT = 1'b0;

        model_frame(25, 8'h37, 8'h00, 8'h19, 8'h05, 1'b0);
        run_scenario(25, 2, hi_start[3] - 100);
        check("en_drop_error_pulses", 32'(err_cnt), 32'd0);
        check("en_drop_done_pulses", 32'(done_cnt), 32'd0);

        model_frame(25, 8'h37, 8'h00, 8'h19, 8'h05, 1'b0);
        run_scenario(25, 3, hi_start[5] - 60);
        check("rst_error_pulses", 32'(err_cnt), 32'd0);
        check("rst_done_pulses", 32'(done_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
